// File: rtl/fp_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fp_issue_ctrl                                                     |
// | Issue/retire control between FP decode and a pipelined FPU: scoreboard,    |
// | in-order destination FIFO, drain and flush sequencing.                     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module fp_issue_ctrl #(
  parameter int MAX_OUTST = 4,
  parameter int ADDR_W    = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         core_valid_i,
  input  logic [3*ADDR_W-1:0]          rs_addr_i,
  input  logic [2:0]                   rs_use_i,
  input  logic [ADDR_W-1:0]            rd_addr_i,
  input  logic                         rd_we_i,
  output logic                         core_stall_o,
  output logic                         fpu_in_valid_o,
  input  logic                         fpu_in_ready_i,
  input  logic                         fpu_out_valid_i,
  output logic                         fpu_out_ready_o,
  input  logic                         wb_block_i,
  output logic                         wb_we_o,
  output logic [ADDR_W-1:0]            wb_addr_o,
  input  logic                         drain_req_i,
  output logic                         drain_ack_o,
  input  logic                         flush_i,
  output logic                         fpu_flush_o,
  output logic [$clog2(MAX_OUTST):0]   outst_cnt_o
);

  localparam int c_PTR_W = $clog2(MAX_OUTST);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_NREG  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_fpu_flush;
  logic [c_NREG-1:0]    r_pending;
  logic [MAX_OUTST-1:0] r_fifo_we;
  logic [ADDR_W-1:0]    r_fifo_addr [MAX_OUTST];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_cnt;

  logic                 w_hazard;
  logic                 w_not_full;
  logic                 w_not_empty;
  logic                 w_fire;
  logic                 w_pop;
  logic                 w_head_we;
  logic [ADDR_W-1:0]    w_head_addr;
  logic [c_NREG-1:0]    w_set;
  logic [c_NREG-1:0]    w_clr;

  assign w_not_full  = (r_cnt != c_CNT_W'(MAX_OUTST));
  assign w_not_empty = (r_cnt != '0);

  // Hazard looks only at the registered scoreboard: a retire in this cycle
  // unblocks a dependent instruction one cycle later, never the same cycle.
  always_comb begin
    w_hazard = rd_we_i & r_pending[rd_addr_i];
    for (int i = 0; i < 3; i++) begin
      w_hazard = w_hazard | (rs_use_i[i] & r_pending[rs_addr_i[i*ADDR_W +: ADDR_W]]);
    end
  end

  assign fpu_in_valid_o  = core_valid_i & (r_state == ST_RUN) & ~w_hazard & w_not_full;
  assign w_fire          = fpu_in_valid_o & fpu_in_ready_i;
  assign core_stall_o    = core_valid_i & ~w_fire;

  assign w_head_we       = r_fifo_we[r_rd_ptr];
  assign w_head_addr     = r_fifo_addr[r_rd_ptr];
  assign fpu_out_ready_o = (r_state != ST_FLUSH) & ~wb_block_i & w_not_empty;
  assign w_pop           = fpu_out_valid_i & fpu_out_ready_o;
  assign wb_we_o         = w_pop & w_head_we;
  assign wb_addr_o       = wb_we_o ? w_head_addr : '0;

  assign drain_ack_o     = (r_state == ST_DRAIN) & ~w_not_empty;
  assign fpu_flush_o     = r_fpu_flush;
  assign outst_cnt_o     = r_cnt;

  // Set is applied after clear so an issue to the retiring address wins.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_fire && rd_we_i) w_set[rd_addr_i]   = 1'b1;
    if (wb_we_o)           w_clr[w_head_addr] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_RUN;
      r_fpu_flush <= 1'b0;
    end else if (flush_i) begin
      r_state     <= ST_FLUSH;
      r_fpu_flush <= 1'b1;
    end else begin
      r_fpu_flush <= 1'b0;
      case (r_state)
        ST_RUN:   if (drain_req_i)  r_state <= ST_DRAIN;
        ST_DRAIN: if (!drain_req_i) r_state <= ST_RUN;
        ST_FLUSH: r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pending <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      r_fifo_we <= '0;
      for (int i = 0; i < MAX_OUTST; i++) r_fifo_addr[i] <= '0;
    end else if (r_state == ST_FLUSH) begin
      r_pending <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_fire) begin
        r_fifo_we[r_wr_ptr]   <= rd_we_i;
        r_fifo_addr[r_wr_ptr] <= rd_addr_i;
        r_wr_ptr              <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_fire, w_pop})
        2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end

endmodule
`default_nettype wire
